// File: rtl/up_core_pkg.sv
// up_core_pkg: shared constants for the parametrised multicycle core.
//   - 4-bit opcode encodings
//   - FSM state encodings (plain constants so older tools can read them)
//   - instruction field offsets measured down from the MSB of IR
//   - memory RW encodings and small opcode-class helpers
package up_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_IMM    = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  // Field MSB position is DATA_W - <offset>.
  localparam int OPC_OFS = 1;
  localparam int P1_OFS  = 5;
  localparam int P2_OFS  = 11;
  localparam int FIELD_W = 6;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op >= OP_MOV) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/up_alu_param.sv
// up_alu_param: combinational ALU for the core.
//   op     : opcode from IR (ADD/SUB/AND/OR/XOR/NOT; anything else passes b)
//   a, b   : rd and rs operands
//   c_in   : current carry flag, returned unchanged for logic ops
//   result : ALU result, modulo 2^DATA_W
//   z, c   : zero flag of result, carry/borrow out
module up_alu_param #(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);
  import up_core_pkg::*;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Zero-extended subtract: the extra MSB is set exactly when a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = b;
    c      = c_in;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        c      = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = b;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/up_core_param.sv
// up_core_param: parametrised multicycle core (PC, IR/decode, register
// file, ALU flags and memory handshake FSM).
//   clk, reset          : clock, synchronous active-high reset
//   data_in, MFC        : memory read data / function complete
//   data_out, address   : memory write data / address (registered)
//   RW, EN              : 1=read 0=write / memory request (registered)
//   halted, fault       : stopped by HALT / memory timeout
//   pc_dbg              : current PC
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_FETCH  | read instruction at PC (raises EN itself if entered idle)
// ST_DECODE | one cycle, EN=0; routes by opcode, pre-issues IMM/MEM
// ST_IMM    | read immediate word at PC (LDI/JMP/JZ/JC)
// ST_MEM    | LD read from R[rs] or ST write to R[rd]
// ST_EXEC   | one cycle ALU/MOV/NOP; pre-issues next fetch
// ST_HALT   | stopped until reset
// ST_FAULT  | memory timeout, stopped until reset
module up_core_param #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int          NREG     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              MFC,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] address,
  output logic              RW,
  output logic              EN,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W-1:0] pc_dbg
);
  import up_core_pkg::*;

  localparam int RIDX_W = $clog2(NREG);
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(TIMEOUT);
  localparam logic TO_ENABLE = (TIMEOUT > 0);

  logic [DATA_W-1:0]  rf [NREG];
  logic [DATA_W-1:0]  ir;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  mem_addr;
  logic [2:0]         state;
  logic [TCNT_W-1:0]  tcnt;
  logic               z_flag;
  logic               c_flag;

  logic [3:0]         opcode;
  logic [FIELD_W-1:0] p1;
  logic [FIELD_W-1:0] p2;
  logic [RIDX_W-1:0]  rd;
  logic [RIDX_W-1:0]  rs;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_z;
  logic               alu_c;
  logic               mem_done;
  logic               timed_out;
  logic               branch_taken;
  logic               unused_bits;

  assign opcode = ir[DATA_W-OPC_OFS -: 4];
  assign p1     = ir[DATA_W-P1_OFS -: FIELD_W];
  assign p2     = ir[DATA_W-P2_OFS -: FIELD_W];
  assign rd     = p1[RIDX_W-1:0];
  assign rs     = p2[RIDX_W-1:0];
  assign rd_val = rf[rd];
  assign rs_val = rf[rs];
  assign pc_inc = pc + ADDR_W'(1);
  assign pc_dbg = pc;

  assign mem_addr = (opcode == OP_LD) ? rs_val[ADDR_W-1:0] : rd_val[ADDR_W-1:0];

  // MFC only counts while a request is outstanding.
  assign mem_done  = EN & MFC;
  // Down-counter loaded at each new access; terminal count while still
  // waiting means the memory never answered.
  assign timed_out = TO_ENABLE & EN & ~MFC & (tcnt == '0);

  assign branch_taken = (opcode == OP_JMP) |
                        ((opcode == OP_JZ) & z_flag) |
                        ((opcode == OP_JC) & c_flag);

  assign unused_bits = ^{p1, p2, data_in};

  up_alu_param #(.DATA_W(DATA_W)) u_alu (
    .op     (opcode),
    .a      (rd_val),
    .b      (rs_val),
    .c_in   (c_flag),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      ir       <= '0;
      pc       <= ADDR_W'(RESET_PC);
      state    <= ST_FETCH;
      tcnt     <= TCNT_LOAD;
      z_flag   <= 1'b0;
      c_flag   <= 1'b0;
      EN       <= 1'b0;
      RW       <= RW_READ;
      address  <= '0;
      data_out <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!EN) begin
            // Entered after a completed access: this cycle is the EN=0 gap.
            EN      <= 1'b1;
            address <= pc;
            RW      <= RW_READ;
            tcnt    <= TCNT_LOAD;
          end else if (mem_done) begin
            ir    <= data_in;
            pc    <= pc_inc;
            EN    <= 1'b0;
            state <= ST_DECODE;
          end else if (timed_out) begin
            EN    <= 1'b0;
            fault <= 1'b1;
            state <= ST_FAULT;
          end else begin
            tcnt <= tcnt - TCNT_W'(1);
          end
        end

        ST_DECODE: begin
          case (opcode)
            OP_LDI, OP_JMP, OP_JZ, OP_JC: begin
              EN      <= 1'b1;
              address <= pc;
              RW      <= RW_READ;
              tcnt    <= TCNT_LOAD;
              state   <= ST_IMM;
            end
            OP_LD, OP_ST: begin
              EN      <= 1'b1;
              address <= mem_addr;
              RW      <= (opcode == OP_LD) ? RW_READ : RW_WRITE;
              if (opcode == OP_ST) data_out <= rs_val;
              tcnt    <= TCNT_LOAD;
              state   <= ST_MEM;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: state <= ST_EXEC;
          endcase
        end

        ST_IMM: begin
          if (mem_done) begin
            EN    <= 1'b0;
            state <= ST_FETCH;
            if (branch_taken) pc <= data_in[ADDR_W-1:0];
            else              pc <= pc_inc;
            if (opcode == OP_LDI) rf[rd] <= data_in;
          end else if (timed_out) begin
            EN    <= 1'b0;
            fault <= 1'b1;
            state <= ST_FAULT;
          end else begin
            tcnt <= tcnt - TCNT_W'(1);
          end
        end

        ST_MEM: begin
          if (mem_done) begin
            EN    <= 1'b0;
            state <= ST_FETCH;
            if (opcode == OP_LD) rf[rd] <= data_in;
          end else if (timed_out) begin
            EN    <= 1'b0;
            fault <= 1'b1;
            state <= ST_FAULT;
          end else begin
            tcnt <= tcnt - TCNT_W'(1);
          end
        end

        ST_EXEC: begin
          if (op_writes_rd(opcode)) rf[rd] <= alu_res;
          if (op_sets_flags(opcode)) begin
            z_flag <= alu_z;
            c_flag <= alu_c;
          end
          // DECODE and EXEC both had EN=0, so the next fetch can issue now.
          EN      <= 1'b1;
          address <= pc;
          RW      <= RW_READ;
          tcnt    <= TCNT_LOAD;
          state   <= ST_FETCH;
        end

        ST_HALT: EN <= 1'b0;

        ST_FAULT: EN <= 1'b0;

        default: begin
          EN    <= 1'b0;
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_core_param.sv
module tb_up_core_param;
  import up_core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- DUT A: 16-bit, NREG=8, RESET_PC=0x10, TIMEOUT=4
  logic        a_reset;
  logic [15:0] a_data_in, a_data_out, a_address, a_pc;
  logic        a_mfc, a_rw, a_en, a_halted, a_fault;

  up_core_param #(.DATA_W(16), .ADDR_W(16), .NREG(8), .RESET_PC(16'h10), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(a_reset), .data_in(a_data_in), .MFC(a_mfc),
    .data_out(a_data_out), .address(a_address), .RW(a_rw), .EN(a_en),
    .halted(a_halted), .fault(a_fault), .pc_dbg(a_pc));

  // ---------------- DUT B: 32-bit, NREG=4, RESET_PC=0
  logic        b_reset;
  logic [31:0] b_data_in, b_data_out;
  logic [15:0] b_address, b_pc;
  logic        b_mfc, b_rw, b_en, b_halted, b_fault;

  up_core_param #(.DATA_W(32), .ADDR_W(16), .NREG(4), .RESET_PC(0), .TIMEOUT(255)) dut_b (
    .clk(clk), .reset(b_reset), .data_in(b_data_in), .MFC(b_mfc),
    .data_out(b_data_out), .address(b_address), .RW(b_rw), .EN(b_en),
    .halted(b_halted), .fault(b_fault), .pc_dbg(b_pc));

  // ---------------- memory models
  logic [15:0] mem [256];
  logic [31:0] bmem [256];
  int          a_delay = 0;
  bit          a_block = 0;
  int          wr_count = 0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  int          gap_err = 0;
  int          unstable_err = 0;
  int          en_cycles = 0;

  initial begin
    int          wcnt;
    bit          last_done;
    bit          prev_en;
    logic [15:0] prev_addr;
    wcnt = 0; last_done = 0; prev_en = 0; prev_addr = '0;
    a_mfc = 1'b0; a_data_in = '0;
    forever begin
      @(negedge clk);
      if (a_en && last_done) gap_err++;
      if (a_en && prev_en && !last_done && a_address != prev_addr) unstable_err++;
      if (a_en) en_cycles++;
      a_mfc = 1'b0;
      if (a_en && !a_block) begin
        if (wcnt >= a_delay) begin
          a_mfc = 1'b1;
          a_data_in = mem[a_address[7:0]];
          if (!a_rw) begin
            mem[a_address[7:0]] = a_data_out;
            wr_count++;
            wr_addr = a_address;
            wr_data = a_data_out;
          end
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (!a_en) begin
        wcnt = 0;
      end
      last_done = a_en && a_mfc;
      prev_en   = a_en;
      prev_addr = a_address;
    end
  end

  initial begin
    b_mfc = 1'b0; b_data_in = '0;
    forever begin
      @(negedge clk);
      b_mfc = b_en;
      b_data_in = bmem[b_address[7:0]];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers
  function automatic logic [15:0] ins(input logic [3:0] op, input int p1, input int p2);
    return {op, 6'(p1), 6'(p2)};
  endfunction

  function automatic logic [31:0] ins32(input logic [3:0] op, input int p1, input int p2);
    return {op, 6'(p1), 6'(p2), 16'h0000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic start_a();
    @(negedge clk);
    a_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en_cycles = 0;
    wr_count  = 0;
    a_reset   = 1'b0;
  endtask

  task automatic wait_stop_a(input int max_cycles, output bit stopped);
    stopped = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (a_halted || a_fault) begin
        stopped = 1;
        break;
      end
    end
  endtask

  task automatic run_prog(input string name);
    bit ok;
    start_a();
    wait_stop_a(200, ok);
    check({name, "_halted"}, {a_halted, a_fault}, 2'b10);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        c;
  } alu_vec_t;

  alu_vec_t vecs [9];

  initial begin
    bit ok;
    a_reset = 1'b1;
    b_reset = 1'b1;

    vecs[0] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[1] = '{OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
    vecs[2] = '{OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1};
    vecs[3] = '{OP_SUB, 16'h0007, 16'h0007, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
    vecs[5] = '{OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0};
    vecs[6] = '{OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0};
    vecs[8] = '{OP_MOV, 16'h1111, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0};

    // ---- reset state and first fetch
    clear_mem();
    mem[16'h10] = ins(OP_HALT, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_en",       a_en,       1'b0);
    check("rst_rw",       a_rw,       1'b1);
    check("rst_address",  a_address,  16'h0000);
    check("rst_data_out", a_data_out, 16'h0000);
    check("rst_halted",   a_halted,   1'b0);
    check("rst_fault",    a_fault,    1'b0);
    check("rst_pc",       a_pc,       16'h0010);
    check("rst_flags",    {dut_a.z_flag, dut_a.c_flag}, 2'b00);
    a_reset = 1'b0;
    @(negedge clk);
    check("first_fetch", {a_en, a_rw, a_address}, {1'b1, 1'b1, 16'h0010});

    // ---- table-driven ALU vectors: LDI r1,#a; LDI r2,#b; OP r1,r2; HALT
    for (int i = 0; i < 9; i++) begin
      clear_mem();
      mem[16'h10] = ins(OP_LDI, 1, 0);
      mem[16'h11] = vecs[i].a;
      mem[16'h12] = ins(OP_LDI, 2, 0);
      mem[16'h13] = vecs[i].b;
      mem[16'h14] = ins(vecs[i].op, 1, 2);
      mem[16'h15] = ins(OP_HALT, 0, 0);
      run_prog($sformatf("vec%0d", i));
      check($sformatf("vec%0d_res", i), dut_a.rf[1], vecs[i].res);
      check($sformatf("vec%0d_z", i),   dut_a.z_flag, vecs[i].z);
      check($sformatf("vec%0d_c", i),   dut_a.c_flag, vecs[i].c);
    end

    // ---- ADD latency: result lands 3 cycles after its fetch EN cycle
    clear_mem();
    mem[16'h10] = ins(OP_LDI, 1, 0);
    mem[16'h11] = 16'hFFFF;
    mem[16'h12] = ins(OP_LDI, 2, 0);
    mem[16'h13] = 16'h0001;
    mem[16'h14] = ins(OP_ADD, 1, 2);
    mem[16'h15] = ins(OP_HALT, 0, 0);
    start_a();
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_en && a_address == 16'h0014) begin
        ok = 1;
        break;
      end
    end
    check("add_fetch_seen", ok, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("add_before", dut_a.rf[1], 16'hFFFF);
    @(negedge clk);
    check("add_after", dut_a.rf[1], 16'h0000);
    check("add_flags", {dut_a.z_flag, dut_a.c_flag}, 2'b11);
    check("add_next_fetch", {a_en, a_address}, {1'b1, 16'h0015});
    wait_stop_a(20, ok);
    check("add_halt", ok, 1'b1);

    // ---- HALT keeps EN low
    en_cycles = 0;
    repeat (20) @(negedge clk);
    check("halt_en_quiet", en_cycles, 0);
    check("halt_stays",    a_halted,  1'b1);

    // ---- ST then LD
    clear_mem();
    mem[16'h10] = ins(OP_LDI, 3, 0);
    mem[16'h11] = 16'h0040;
    mem[16'h12] = ins(OP_LDI, 1, 0);
    mem[16'h13] = 16'h1234;
    mem[16'h14] = ins(OP_ST, 3, 1);
    mem[16'h15] = ins(OP_LD, 4, 3);
    mem[16'h16] = ins(OP_LDI, 2, 0);
    mem[16'h17] = 16'h0041;
    mem[16'h18] = ins(OP_LD, 5, 2);
    mem[16'h19] = ins(OP_HALT, 0, 0);
    mem[16'h41] = 16'hBEEF;
    run_prog("stld");
    check("st_count", wr_count, 1);
    check("st_addr",  wr_addr, 16'h0040);
    check("st_data",  wr_data, 16'h1234);
    check("ld_r4",    dut_a.rf[4], 16'h1234);
    check("ld_r5",    dut_a.rf[5], 16'hBEEF);

    // ---- JZ taken (SUB r1,r1 -> 0, Z=1)
    clear_mem();
    mem[16'h10] = ins(OP_LDI, 1, 0);
    mem[16'h11] = 16'h0005;
    mem[16'h12] = ins(OP_SUB, 1, 1);
    mem[16'h13] = ins(OP_JZ, 0, 0);
    mem[16'h14] = 16'h0020;
    mem[16'h15] = ins(OP_HALT, 0, 0);
    mem[16'h20] = ins(OP_HALT, 0, 0);
    run_prog("jz_t");
    check("jz_t_pc",   a_pc, 16'h0021);
    check("jz_t_r1",   dut_a.rf[1], 16'h0000);
    check("jz_t_z",    dut_a.z_flag, 1'b1);

    // ---- JZ not taken: falls through to instruction address + 2
    clear_mem();
    mem[16'h10] = ins(OP_LDI, 1, 0);
    mem[16'h11] = 16'h0005;
    mem[16'h12] = ins(OP_LDI, 2, 0);
    mem[16'h13] = 16'h0001;
    mem[16'h14] = ins(OP_SUB, 1, 2);
    mem[16'h15] = ins(OP_JZ, 0, 0);
    mem[16'h16] = 16'h0020;
    mem[16'h17] = ins(OP_HALT, 0, 0);
    mem[16'h20] = ins(OP_HALT, 0, 0);
    run_prog("jz_n");
    check("jz_n_pc", a_pc, 16'h0018);
    check("jz_n_r1", dut_a.rf[1], 16'h0004);

    // ---- JC taken on borrow
    clear_mem();
    mem[16'h10] = ins(OP_LDI, 1, 0);
    mem[16'h11] = 16'h0005;
    mem[16'h12] = ins(OP_LDI, 2, 0);
    mem[16'h13] = 16'h0007;
    mem[16'h14] = ins(OP_SUB, 1, 2);
    mem[16'h15] = ins(OP_JC, 0, 0);
    mem[16'h16] = 16'h0030;
    mem[16'h17] = ins(OP_HALT, 0, 0);
    mem[16'h30] = ins(OP_HALT, 0, 0);
    run_prog("jc");
    check("jc_pc", a_pc, 16'h0031);

    // ---- logic op keeps C, MOV keeps flags
    clear_mem();
    mem[16'h10] = ins(OP_LDI, 1, 0);
    mem[16'h11] = 16'hFFFF;
    mem[16'h12] = ins(OP_LDI, 2, 0);
    mem[16'h13] = 16'h0001;
    mem[16'h14] = ins(OP_ADD, 1, 2);
    mem[16'h15] = ins(OP_AND, 1, 2);
    mem[16'h16] = ins(OP_MOV, 3, 2);
    mem[16'h17] = ins(OP_HALT, 0, 0);
    run_prog("cflag");
    check("cflag_zc", {dut_a.z_flag, dut_a.c_flag}, 2'b11);
    check("cflag_r3", dut_a.rf[3], 16'h0001);

    // ---- delayed MFC on a fetch: 3 and 4 wait cycles, no fault
    clear_mem();
    mem[16'h10] = ins(OP_HALT, 0, 0);
    a_delay = 3;
    run_prog("dly3");
    check("dly3_en_cycles", en_cycles, 4);
    check("dly3_fault", a_fault, 1'b0);
    a_delay = 4;
    run_prog("dly4");
    check("dly4_en_cycles", en_cycles, 5);
    a_delay = 0;

    // ---- timeout: MFC never comes
    a_block = 1;
    start_a();
    wait_stop_a(30, ok);
    check("to_fault",     {ok, a_fault, a_en}, 3'b110);
    check("to_en_cycles", en_cycles, 5);
    @(negedge clk);
    a_reset = 1'b1;
    @(negedge clk);
    check("to_reset_clears", a_fault, 1'b0);

    // ---- reset mid-access drops EN next cycle
    start_a();
    ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_en) begin
        ok = 1;
        break;
      end
    end
    check("mid_en_seen", ok, 1'b1);
    a_reset = 1'b1;
    @(negedge clk);
    check("mid_en_drop", a_en, 1'b0);
    a_block = 0;

    check("gap_violations", gap_err, 0);
    check("addr_unstable",  unstable_err, 0);

    // ---- 32-bit / NREG=4 build; p1=5,p2=6 alias to r1,r2
    for (int i = 0; i < 256; i++) bmem[i] = '0;
    bmem[0] = ins32(OP_LDI, 1, 0);
    bmem[1] = 32'hFFFF_FFFF;
    bmem[2] = ins32(OP_LDI, 2, 0);
    bmem[3] = 32'h0000_0001;
    bmem[4] = ins32(OP_ADD, 5, 6);
    bmem[5] = ins32(OP_HALT, 0, 0);
    @(negedge clk);
    b_reset = 1'b0;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_halted) begin
        ok = 1;
        break;
      end
    end
    check("w32_halted", ok, 1'b1);
    check("w32_r1",     dut_b.rf[1], 32'h0000_0000);
    check("w32_r2",     dut_b.rf[2], 32'h0000_0001);
    check("w32_zc",     {dut_b.z_flag, dut_b.c_flag}, 2'b11);
    check("w32_pc",     b_pc, 16'h0006);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
